barrett_reduce: RTL and testbench

Multi-cycle Barrett modular reducer that sits directly downstream of the Booth radix-4 multiplier in the NTT butterfly datapath. It captures the 2N-bit product when the multiplier raises `done`, and returns `x mod Q` as an N-bit residue with the same start/done pulse handshake. The butterfly add/sub stage consumes this residue.

---
 rtl/ntt_pkg.sv | 31 +++
 rtl/cond_sub_q.sv | 17 +
 rtl/barrett_reduce.sv | 134 +++++++++++++
 tb/tb_barrett_reduce.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared constants, types and helpers for the NTT butterfly datapath
// (Barrett reducer, butterfly add/sub stage, twiddle ROM).
//   NTT_N / NTT_Q        : default residue width and modulus
//   NTT_W_Q/NTT_W_R/NTT_W_T : quotient (N+1), remainder (N+2), product (2N+2) widths
//   barrett_state_t      : Barrett reducer FSM states
//   barrett_mu()         : floor(2^(2N) / Q)
package ntt_pkg;

    localparam int NTT_N   = 14;
    localparam int NTT_Q   = 12289;
    localparam int NTT_W_Q = NTT_N + 1;
    localparam int NTT_W_R = NTT_N + 2;
    localparam int NTT_W_T = 2 * NTT_N + 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULQ = 3'd1,
        ST_MULR = 3'd2,
        ST_SUB  = 3'd3,
        ST_COR1 = 3'd4,
        ST_COR2 = 3'd5
    } barrett_state_t;

    function automatic longint barrett_mu(input int n, input int q);
        longint num;
        num = longint'(1) << (2 * n);
        return num / longint'(q);
    endfunction

endpackage

// File: rtl/cond_sub_q.sv
// cond_sub_q
// Combinational conditional subtract: y = (r >= Q) ? r - Q : r.
//   r : input  [W-1:0]  partially reduced remainder
//   y : output [W-1:0]  remainder after at most one subtraction of Q
module cond_sub_q #(
    parameter int W = 16,
    parameter int Q = 12289
) (
    input  logic [W-1:0] r,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] Q_W = W'(Q);

    assign y = (r >= Q_W) ? (r - Q_W) : r;

endmodule

// File: rtl/barrett_reduce.sv
// barrett_reduce
// Multi-cycle Barrett reducer: captures a 2N-bit product on start and
// returns x mod Q after a fixed 5-clock latency with a one-cycle done pulse.
//   clk       : input        rising-edge clock
//   n_reset   : input        asynchronous active-low reset
//   start     : input        load request (upstream multiplier done)
//   x         : input  [2N]  unsigned product, expected < Q*Q
//   result    : output [N]   residue, held until the next completion
//   done      : output       one-cycle completion pulse
//   busy      : output       reduction in flight
//   range_err : output       sticky x >= Q*Q flag, only with BARRETT_RANGE_CHECK_EN
// Optional feature macro: BARRETT_RANGE_CHECK_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; done cycle of the previous op lands here
// MULQ  | q = ((x >> (N-1)) * MU) >> (N+1)
// MULR  | qm = q * Q, kept to N+2 bits
// SUB   | r = x - qm mod 2^(N+2), r < 3Q
// COR1  | first conditional subtract of Q
// COR2  | second conditional subtract, load result, pulse done
module barrett_reduce
    import ntt_pkg::*;
#(
    parameter int N = NTT_N,
    parameter int Q = NTT_Q
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic           start,
    input  logic [2*N-1:0] x,
    output logic [N-1:0]   result,
    output logic           done,
    output logic           busy
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    output logic           range_err
`endif
);

    localparam logic [N:0]   MU_W = (N + 1)'(barrett_mu(N, Q));
    localparam logic [N+1:0] Q_R  = (N + 2)'(Q);

    barrett_state_t state;

    logic [2*N-1:0] x_reg;
    logic [N:0]     q;
    logic [N+1:0]   qm;
    logic [N+1:0]   r;

    logic [N:0]     x_hi;
    logic [2*N+1:0] t;
    logic [N:0]     q_next;
    logic [N+1:0]   qm_next;
    logic [N+1:0]   r_corr;

    assign x_hi    = (N + 1)'(x_reg >> (N - 1));
    assign t       = {{(N + 1){1'b0}}, x_hi} * {{(N + 1){1'b0}}, MU_W};
    assign q_next  = (N + 1)'(t >> (N + 1));
    // Only the low N+2 bits of q*Q matter: the true remainder is < 3Q < 2^(N+2).
    assign qm_next = {1'b0, q} * Q_R;

    // Shared between COR1 and COR2.
    cond_sub_q #(
        .W (N + 2),
        .Q (Q)
    ) u_cond_sub (
        .r (r),
        .y (r_corr)
    );

`ifdef BARRETT_RANGE_CHECK_EN
    localparam logic [2*N-1:0] QQ = (2 * N)'(longint'(Q) * longint'(Q));
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= ST_IDLE;
            x_reg  <= '0;
            q      <= '0;
            qm     <= '0;
            r      <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef BARRETT_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_reg <= x;
                        busy  <= 1'b1;
                        state <= ST_MULQ;
`ifdef BARRETT_RANGE_CHECK_EN
                        if (x >= QQ) begin
                            range_err <= 1'b1;
                        end
`endif
                    end
                end
                ST_MULQ: begin
                    q     <= q_next;
                    state <= ST_MULR;
                end
                ST_MULR: begin
                    qm    <= qm_next;
                    state <= ST_SUB;
                end
                ST_SUB: begin
                    r     <= x_reg[N+1:0] - qm;
                    state <= ST_COR1;
                end
                ST_COR1: begin
                    r     <= r_corr;
                    state <= ST_COR2;
                end
                ST_COR2: begin
                    result <= N'(r_corr);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_reduce.sv
// tb_barrett_reduce
// Self-checking bench for barrett_reduce: directed vectors, random vectors
// against a plain x % Q model, start-ignore, back-to-back and mid-op reset.
// Range-check scenarios are compiled only with BARRETT_RANGE_CHECK_EN.
module tb_barrett_reduce;

    localparam int N = 14;
    localparam int Q = 12289;
    localparam int QQ = Q * Q;

    logic          clk;
    logic          n_reset;
    logic          start;
    logic [2*N-1:0] x;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;
`ifdef BARRETT_RANGE_CHECK_EN
    logic          range_err;
`endif

    int tests_run;
    int tests_failed;

    barrett_reduce #(.N(N), .Q(Q)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .x         (x),
        .result    (result),
        .done      (done),
        .busy      (busy)
`ifdef BARRETT_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] model(input logic [2*N-1:0] xv);
        longint v;
        v = longint'(xv) % longint'(Q);
        return N'(v);
    endfunction

    // Drives one operation starting in the current cycle (called #1 after an edge).
    // Returns in the done cycle so a following call lands start there.
    task automatic do_op(input logic [2*N-1:0] xv, input logic [N-1:0] prev_res,
                         output logic [N-1:0] res, output int lat, output bit got,
                         output bit busy_ok, output bit stable);
        start = 1'b1;
        x     = xv;
        @(posedge clk); #1;
        start = 1'b0;
        x     = (2*N)'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (result !== prev_res) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        got = (done === 1'b1);
        if (got && busy !== 1'b0) busy_ok = 1'b0;
        res = result;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        start   = 1'b0;
        x       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (result !== '0) begin
            tests_failed++;
            $display("FAIL reset_result: got %0d, required 0", result);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b, required 0", done);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
`ifdef BARRETT_RANGE_CHECK_EN
        tests_run++;
        if (range_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_range_err: got %b, required 0", range_err);
        end
`endif
    endtask

    task automatic test_directed();
        logic [2*N-1:0] dx   [6];
        logic [N-1:0]   dexp [6];
        logic [N-1:0]   prev;
        logic [N-1:0]   res;
        int lat;
        bit got, bok, stb;
        dx   = '{28'd0, 28'd12289, 28'd12290, 28'd100000, 28'd150994944, 28'd151019520};
        dexp = '{14'd0, 14'd0, 14'd1, 14'd1688, 14'd1, 14'd12288};
        prev = result;
        for (int i = 0; i < 6; i++) begin
            do_op(dx[i], prev, res, lat, got, bok, stb);
            tests_run++;
            if (!got) begin
                tests_failed++;
                $display("FAIL directed_timeout[%0d]: no done within 20 clocks, required done", i);
            end
            tests_run++;
            if (res !== dexp[i]) begin
                tests_failed++;
                $display("FAIL directed_result x=%0d: got %0d, required %0d", dx[i], res, dexp[i]);
            end
            tests_run++;
            if (lat != 5) begin
                tests_failed++;
                $display("FAIL directed_latency x=%0d: got %0d, required 5", dx[i], lat);
            end
            tests_run++;
            if (!bok) begin
                tests_failed++;
                $display("FAIL directed_busy x=%0d: busy not high E0..E4 / low at done, required covered", dx[i]);
            end
            prev = res;
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_done_width x=%0d: done=%b one cycle later, required 0", dx[i], done);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (result !== 14'd12288) begin
            tests_failed++;
            $display("FAIL directed_hold: got %0d, required 12288", result);
        end
    endtask

    task automatic test_random();
        logic [2*N-1:0] xv;
        logic [N-1:0]   prev;
        logic [N-1:0]   res;
        logic [N-1:0]   exp;
        int lat;
        bit got, bok, stb;
        prev = result;
        for (int i = 0; i < 10000; i++) begin
            if ((i % 16) == 0) xv = (2*N)'($urandom_range(QQ - 1, QQ - 40000));
            else               xv = (2*N)'($urandom_range(QQ - 1, 0));
            exp = model(xv);
            do_op(xv, prev, res, lat, got, bok, stb);
            tests_run++;
            if (!got || res !== exp || lat != 5 || !bok || !stb) begin
                tests_failed++;
                $display("FAIL random[%0d] x=%0d: got res=%0d lat=%0d done=%b busy_ok=%b stable=%b, required res=%0d lat=5 done=1 busy_ok=1 stable=1",
                         i, xv, res, lat, got, bok, stb, exp);
            end
            prev = res;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        logic [2*N-1:0] xv;
        logic [N-1:0]   exp;
        bit extra_busy;
        xv  = 28'd100000;
        exp = model(xv);
        start = 1'b1; x = xv;
        @(posedge clk); #1;          // after E0: MULQ
        start = 1'b0; x = 28'd12290;
        @(posedge clk); #1;          // after E1: MULR
        start = 1'b1;
        @(posedge clk); #1;          // after E2: SUB
        start = 1'b0;
        @(posedge clk); #1;          // after E3: COR1
        start = 1'b1; x = 28'd7;
        @(posedge clk); #1;          // after E4: COR2
        start = 1'b0;
        @(posedge clk); #1;          // after E5
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_done: got %b after E5, required 1", done);
        end
        tests_run++;
        if (result !== exp) begin
            tests_failed++;
            $display("FAIL ignore_result: got %0d, required %0d", result, exp);
        end
        extra_busy = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) extra_busy = 1'b1;
        end
        tests_run++;
        if (extra_busy) begin
            tests_failed++;
            $display("FAIL ignore_no_extra_op: busy/done seen after completion, required idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] xs [3];
        logic [N-1:0]   prev;
        logic [N-1:0]   res;
        int lat;
        bit got, bok, stb;
        xs = '{28'd150994944, 28'd12290, 28'd100000};
        prev = result;
        for (int i = 0; i < 3; i++) begin
            do_op(xs[i], prev, res, lat, got, bok, stb);
            tests_run++;
            if (!got || lat != 5 || res !== model(xs[i])) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got done=%b lat=%0d res=%0d, required done=1 lat=5 res=%0d",
                         i, got, lat, res, model(xs[i]));
            end
            prev = res;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] res;
        int lat;
        bit got, bok, stb;
        bit saw_done;
        do_op(28'd100000, result, res, lat, got, bok, stb);
        @(posedge clk); #1;
        start = 1'b1; x = 28'd12290;
        @(posedge clk); #1;          // MULQ
        start = 1'b0;
        @(posedge clk); #1;          // MULR
        @(posedge clk); #1;          // SUB
        n_reset = 1'b0;
        #1;
        tests_run++;
        if (result !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got result=%0d done=%b busy=%b, required 0 0 0", result, done, busy);
        end
        @(negedge clk);
        n_reset = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL reset_mid_aborted: done/busy seen after reset, required none");
        end
        do_op(28'd150994944, 14'd0, res, lat, got, bok, stb);
        tests_run++;
        if (!got || res !== 14'd1 || lat != 5 || !stb) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: got done=%b res=%0d lat=%0d stable=%b, required 1 1 5 1", got, res, lat, stb);
        end
        @(posedge clk); #1;
    endtask

`ifdef BARRETT_RANGE_CHECK_EN
    task automatic test_range_check();
        logic [N-1:0] res;
        int lat;
        bit got, bok, stb;
        apply_reset();
        start = 1'b1; x = 28'(QQ);
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (range_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_err_set: got %b after E0, required 1", range_err);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL range_err_done: no done for out-of-range op, required done");
        end
        do_op(28'd12290, result, res, lat, got, bok, stb);
        tests_run++;
        if (range_err !== 1'b1 || res !== 14'd1) begin
            tests_failed++;
            $display("FAIL range_err_sticky: got range_err=%b res=%0d, required 1 1", range_err, res);
        end
        @(posedge clk); #1;
        apply_reset();
        do_op(28'(QQ - 1), 14'd0, res, lat, got, bok, stb);
        tests_run++;
        if (range_err !== 1'b0 || res !== 14'd12288) begin
            tests_failed++;
            $display("FAIL range_err_edge: got range_err=%b res=%0d, required 0 12288", range_err, res);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_reset = 1'b0;
        start   = 1'b0;
        x       = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BARRETT_RANGE_CHECK_EN
        test_range_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
